pong_engine: RTL and testbench



---
 rtl/pong_pkg.sv | 32 +++
 rtl/pong_if.sv | 25 ++
 rtl/pong_paddle.sv | 34 +++
 rtl/pong_engine.sv | 181 ++++++++++++++++++
 tb/tb_pong_engine.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// Shared types, default geometry and helpers for the two-player pong core.
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    POINT = 2'd2,
    OVER  = 2'd3
  } game_state_t;

  localparam int DEF_POS_W        = 10;
  localparam int DEF_SCREEN_W     = 640;
  localparam int DEF_SCREEN_H     = 480;
  localparam int DEF_BALL_SIZE    = 10;
  localparam int DEF_PADDLE_W     = 10;
  localparam int DEF_PADDLE_H     = 60;
  localparam int DEF_BALL_SPEED   = 2;
  localparam int DEF_PADDLE_SPEED = 2;
  localparam int DEF_TICK_DIV     = 50000;
  localparam int DEF_SCORE_W      = 4;
  localparam int DEF_WIN_SCORE    = 9;
  localparam int DEF_HOLD_TICKS   = 60;

  // Minimum 1 bit so single-value counters still elaborate.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/pong_if.sv
// Player controls in, game view (positions, scores, status) out.
interface pong_if #(
  parameter int POS_W   = pong_pkg::DEF_POS_W,
  parameter int SCORE_W = pong_pkg::DEF_SCORE_W
) ();
  import pong_pkg::*;

  logic               p1_up, p1_down, p2_up, p2_down, serve;
  logic [POS_W-1:0]   ball_x, ball_y, paddle1_y, paddle2_y;
  logic [SCORE_W-1:0] score1, score2;
  game_state_t        game_state;
  logic               point_p1, point_p2, tick;

  modport slave (
    input  p1_up, p1_down, p2_up, p2_down, serve,
    output ball_x, ball_y, paddle1_y, paddle2_y, score1, score2,
           game_state, point_p1, point_p2, tick
  );

  modport master (
    output p1_up, p1_down, p2_up, p2_down, serve,
    input  ball_x, ball_y, paddle1_y, paddle2_y, score1, score2,
           game_state, point_p1, point_p2, tick
  );
endinterface

// File: rtl/pong_paddle.sv
// One paddle: top-edge register moved on frame ticks, clamped to the playfield.
module pong_paddle #(
  parameter int POS_W        = 10,
  parameter int SCREEN_H     = 480,
  parameter int PADDLE_H     = 60,
  parameter int PADDLE_SPEED = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             freeze,
  input  logic             up,
  input  logic             down,
  output logic [POS_W-1:0] y
);
  typedef logic [POS_W:0] ext_t;

  localparam ext_t             Y_MAX = ext_t'(SCREEN_H - PADDLE_H);
  localparam ext_t             SPD   = ext_t'(PADDLE_SPEED);
  localparam logic [POS_W-1:0] Y_RST = POS_W'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [POS_W-1:0] STEP  = POS_W'(PADDLE_SPEED);

  ext_t y_dn;
  assign y_dn = ext_t'(y) + SPD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y <= Y_RST;
    end else if (tick && !freeze && (up ^ down)) begin
      if (up) y <= (ext_t'(y) >= SPD) ? y - STEP : '0;
      else    y <= (y_dn > Y_MAX) ? Y_MAX[POS_W-1:0] : y_dn[POS_W-1:0];
    end
  end
endmodule

// File: rtl/pong_engine.sv
// Two-player pong core: frame tick, ball motion, paddle collision, scoring and game FSM.
module pong_engine
  import pong_pkg::*;
#(
  parameter int POS_W        = DEF_POS_W,
  parameter int SCREEN_W     = DEF_SCREEN_W,
  parameter int SCREEN_H     = DEF_SCREEN_H,
  parameter int BALL_SIZE    = DEF_BALL_SIZE,
  parameter int PADDLE_W     = DEF_PADDLE_W,
  parameter int PADDLE_H     = DEF_PADDLE_H,
  parameter int BALL_SPEED   = DEF_BALL_SPEED,
  parameter int PADDLE_SPEED = DEF_PADDLE_SPEED,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int SCORE_W      = DEF_SCORE_W,
  parameter int WIN_SCORE    = DEF_WIN_SCORE,
  parameter int HOLD_TICKS   = DEF_HOLD_TICKS
) (
  input  logic  clk,
  input  logic  rst_n,
  pong_if.slave io
);
  localparam int CW = clog2(TICK_DIV);
  localparam int HW = clog2(HOLD_TICKS);

  typedef logic [POS_W+1:0] ext_t;
  typedef logic [POS_W-1:0] pos_t;

  localparam pos_t X_CTR   = pos_t'((SCREEN_W - BALL_SIZE) / 2);
  localparam pos_t Y_CTR   = pos_t'((SCREEN_H - BALL_SIZE) / 2);
  localparam pos_t X_LEFT  = pos_t'(PADDLE_W);
  localparam pos_t X_RIGHT = pos_t'(SCREEN_W - PADDLE_W - BALL_SIZE);
  localparam pos_t Y_BOT   = pos_t'(SCREEN_H - BALL_SIZE);
  localparam pos_t STEP    = pos_t'(BALL_SPEED);
  localparam ext_t E_BS    = ext_t'(BALL_SIZE);
  localparam ext_t E_SPD   = ext_t'(BALL_SPEED);
  localparam ext_t E_PH    = ext_t'(PADDLE_H);
  localparam ext_t E_H     = ext_t'(SCREEN_H);
  localparam ext_t L_LIM   = ext_t'(PADDLE_W + BALL_SPEED);
  localparam ext_t R_LIM   = ext_t'(SCREEN_W - PADDLE_W);
  localparam logic [CW-1:0]      CNT_LAST  = CW'(TICK_DIV - 1);
  localparam logic [HW-1:0]      HOLD_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);

  logic [CW-1:0]      cnt;
  logic [HW-1:0]      hold_cnt;
  logic               tick, serve_req, dir_x, dir_y, freeze;
  pos_t               ball_x, ball_y, ny;
  logic               ndy;
  logic [SCORE_W-1:0] score1, score2;
  game_state_t        state;
  logic               point_p1, point_p2;

  logic [1:0][POS_W-1:0] pad_y;
  logic [1:0]            pad_up, pad_dn;

  assign tick   = (cnt == CNT_LAST);
  assign freeze = (state == OVER);
  assign pad_up = {io.p2_up, io.p1_up};
  assign pad_dn = {io.p2_down, io.p1_down};

  for (genvar i = 0; i < 2; i++) begin : g_pad
    pong_paddle #(
      .POS_W(POS_W), .SCREEN_H(SCREEN_H), .PADDLE_H(PADDLE_H), .PADDLE_SPEED(PADDLE_SPEED)
    ) u_pad (
      .clk(clk), .rst_n(rst_n), .tick(tick), .freeze(freeze),
      .up(pad_up[i]), .down(pad_dn[i]), .y(pad_y[i])
    );
  end

  ext_t bx, by, p1, p2;
  logic hit1, hit2, at_left, at_right;
  assign bx       = ext_t'(ball_x);
  assign by       = ext_t'(ball_y);
  assign p1       = ext_t'(pad_y[0]);
  assign p2       = ext_t'(pad_y[1]);
  assign hit1     = (by + E_BS > p1) && (by < p1 + E_PH);
  assign hit2     = (by + E_BS > p2) && (by < p2 + E_PH);
  assign at_left  = !dir_x && (bx < L_LIM);
  assign at_right = dir_x && (bx + E_BS + E_SPD > R_LIM);

  // Vertical step with wall clamp; applied on every PLAY tick, miss ticks included.
  always_comb begin
    ny  = ball_y;
    ndy = dir_y;
    if (!dir_y) begin
      if (by < E_SPD) begin ny = '0; ndy = 1'b1; end
      else ny = ball_y - STEP;
    end else if (by + E_BS + E_SPD > E_H) begin
      ny = Y_BOT; ndy = 1'b0;
    end else ny = ball_y + STEP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      hold_cnt  <= '0;
      serve_req <= 1'b0;
      ball_x    <= X_CTR;
      ball_y    <= Y_CTR;
      dir_x     <= 1'b1;
      dir_y     <= 1'b1;
      score1    <= '0;
      score2    <= '0;
      state     <= IDLE;
      point_p1  <= 1'b0;
      point_p2  <= 1'b0;
    end else begin
      point_p1 <= 1'b0;
      point_p2 <= 1'b0;
      cnt      <= tick ? '0 : cnt + 1'b1;
      // A pending request is consumed by the next tick; a press on a tick with none pending waits for the following one.
      if (tick && serve_req) serve_req <= 1'b0;
      else if (io.serve && (state == IDLE || state == OVER)) serve_req <= 1'b1;
      if (tick) begin
        case (state)
          IDLE: if (serve_req) begin
            state <= PLAY;
            dir_y <= ~dir_y;
          end
          PLAY: begin
            ball_y <= ny;
            dir_y  <= ndy;
            if (at_left) begin
              if (hit1) begin
                ball_x <= X_LEFT;
                dir_x  <= 1'b1;
              end else begin
                if (score2 != WIN) score2 <= score2 + 1'b1;
                point_p2 <= 1'b1;
                dir_x    <= 1'b0;
                hold_cnt <= '0;
                state    <= POINT;
              end
            end else if (at_right) begin
              if (hit2) begin
                ball_x <= X_RIGHT;
                dir_x  <= 1'b0;
              end else begin
                if (score1 != WIN) score1 <= score1 + 1'b1;
                point_p1 <= 1'b1;
                dir_x    <= 1'b1;
                hold_cnt <= '0;
                state    <= POINT;
              end
            end else begin
              ball_x <= dir_x ? ball_x + STEP : ball_x - STEP;
            end
          end
          POINT: if (hold_cnt == HOLD_LAST) begin
            if (score1 == WIN || score2 == WIN) state <= OVER;
            else begin
              state  <= IDLE;
              ball_x <= X_CTR;
              ball_y <= Y_CTR;
            end
          end else hold_cnt <= hold_cnt + 1'b1;
          OVER: if (serve_req) begin
            score1 <= '0;
            score2 <= '0;
            ball_x <= X_CTR;
            ball_y <= Y_CTR;
            dir_x  <= 1'b1;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign io.ball_x     = ball_x;
  assign io.ball_y     = ball_y;
  assign io.paddle1_y  = pad_y[0];
  assign io.paddle2_y  = pad_y[1];
  assign io.score1     = score1;
  assign io.score2     = score2;
  assign io.game_state = state;
  assign io.point_p1   = point_p1;
  assign io.point_p2   = point_p2;
  assign io.tick       = tick;
endmodule

// File: tb/tb_pong_engine.sv
// Directed bench: main core (TICK_DIV=4, WIN_SCORE=2) plus a short-field core for wall clamps.
module tb_pong_engine;
  import pong_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   p1_pulses = 0;
  int   p2_pulses = 0;

  always #5 clk = ~clk;

  pong_if a_if ();
  pong_if b_if ();

  pong_engine #(.TICK_DIV(4), .WIN_SCORE(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .io(a_if.slave)
  );
  pong_engine #(.SCREEN_H(40), .PADDLE_H(20), .TICK_DIV(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .io(b_if.slave)
  );

  always @(posedge clk) begin
    if (a_if.point_p1) p1_pulses++;
    if (a_if.point_p2) p2_pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Returns at the negedge after the tick edge, when tick-driven updates are visible.
  task automatic next_tick();
    int i;
    i = 0;
    while (a_if.tick !== 1'b1 && i < 10) begin
      @(negedge clk);
      i++;
    end
    if (a_if.tick !== 1'b1) begin
      fails++;
      $error("FAIL tick_timeout: observed no tick in %0d cycles, expected one", i);
    end
    @(negedge clk);
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) next_tick();
  endtask

  task automatic serve_a();
    if (a_if.tick) @(negedge clk);
    a_if.serve = 1'b1;
    @(negedge clk);
    a_if.serve = 1'b0;
  endtask

  task automatic serve_b();
    if (b_if.tick) @(negedge clk);
    b_if.serve = 1'b1;
    @(negedge clk);
    b_if.serve = 1'b0;
  endtask

  initial begin
    int ntk;
    int hc;
    {a_if.p1_up, a_if.p1_down, a_if.p2_up, a_if.p2_down, a_if.serve} = '0;
    {b_if.p1_up, b_if.p1_down, b_if.p2_up, b_if.p2_down, b_if.serve} = '0;
    repeat (2) @(negedge clk);

    chk("rst_ball_x", a_if.ball_x, 315);
    chk("rst_ball_y", a_if.ball_y, 235);
    chk("rst_pad1", a_if.paddle1_y, 210);
    chk("rst_pad2", a_if.paddle2_y, 210);
    chk("rst_score1", a_if.score1, 0);
    chk("rst_score2", a_if.score2, 0);
    chk("rst_state", a_if.game_state, 0);
    chk("rst_tick", a_if.tick, 0);
    chk("rst_pts", {a_if.point_p1, a_if.point_p2}, 0);
    chk("rst_b_ball_y", b_if.ball_y, 15);
    chk("rst_b_pad1", b_if.paddle1_y, 10);

    rst_n = 1'b1;
    ntk = 0;
    repeat (40) begin
      @(negedge clk);
      if (a_if.tick) ntk++;
    end
    chk("tick_rate", ntk, 10);

    // Short field: top clamp at 0, bottom clamp at 30
    serve_b();
    next_tick();
    chk("b_play", b_if.game_state, 1);
    next_tick();
    chk("b_y_n1", b_if.ball_y, 13);
    run_ticks(6);
    chk("b_y_n7", b_if.ball_y, 1);
    next_tick();
    chk("b_y_top", b_if.ball_y, 0);
    next_tick();
    chk("b_y_down", b_if.ball_y, 2);
    run_ticks(14);
    chk("b_y_n23", b_if.ball_y, 30);
    next_tick();
    chk("b_y_bot", b_if.ball_y, 30);
    next_tick();
    chk("b_y_up", b_if.ball_y, 28);
    chk("b_x_n25", b_if.ball_x, 365);

    // Paddles in IDLE
    a_if.p1_up = 1'b1;
    a_if.p2_up = 1'b1;
    next_tick();
    chk("pad1_step", a_if.paddle1_y, 208);
    run_ticks(119);
    chk("pad1_top", a_if.paddle1_y, 0);
    chk("pad2_top", a_if.paddle2_y, 0);
    a_if.p1_up = 1'b0;
    a_if.p2_up = 1'b0;
    a_if.p1_down = 1'b1;
    run_ticks(250);
    chk("pad1_bot", a_if.paddle1_y, 420);
    chk("pad2_hold", a_if.paddle2_y, 0);
    a_if.p1_up = 1'b1;
    run_ticks(5);
    chk("pad1_both", a_if.paddle1_y, 420);
    a_if.p1_up = 1'b0;
    a_if.p1_down = 1'b0;
    chk("idle_no_serve", a_if.game_state, 0);

    // Round 1: paddle2 at 0, ball reaches x=619 at y=68 and misses
    serve_a();
    next_tick();
    chk("r1_play", a_if.game_state, 1);
    next_tick();
    chk("r1_x_n1", a_if.ball_x, 317);
    chk("r1_y_n1", a_if.ball_y, 233);
    run_ticks(151);
    chk("r1_x_n152", a_if.ball_x, 619);
    chk("r1_y_n152", a_if.ball_y, 68);
    next_tick();
    chk("r1_miss_x", a_if.ball_x, 619);
    chk("r1_miss_y", a_if.ball_y, 70);
    chk("r1_score1", a_if.score1, 1);
    chk("r1_score2", a_if.score2, 0);
    chk("r1_state", a_if.game_state, 2);
    chk("r1_pulse", {a_if.point_p1, a_if.point_p2}, 2'b10);
    @(negedge clk);
    chk("r1_pulse_end", a_if.point_p1, 0);
    hc = 0;
    while (a_if.game_state == 2 && hc < 100) begin
      next_tick();
      hc++;
    end
    chk("r1_hold_ticks", hc, 60);
    chk("r1_idle", a_if.game_state, 0);
    chk("r1_ctr_x", a_if.ball_x, 315);
    chk("r1_ctr_y", a_if.ball_y, 235);
    chk("r1_p1_pulses", p1_pulses, 1);

    // Round 2: paddle2 at 40 returns the ball; then left miss against paddle1 at 420
    a_if.p2_down = 1'b1;
    run_ticks(20);
    a_if.p2_down = 1'b0;
    chk("pad2_40", a_if.paddle2_y, 40);
    chk("r2_idle", a_if.game_state, 0);
    serve_a();
    next_tick();
    serve_a();
    run_ticks(152);
    chk("r2_x_n152", a_if.ball_x, 619);
    next_tick();
    chk("r2_bounce_x", a_if.ball_x, 620);
    chk("r2_bounce_y", a_if.ball_y, 70);
    chk("r2_bounce_state", a_if.game_state, 1);
    chk("r2_bounce_s1", a_if.score1, 1);
    next_tick();
    chk("r2_left_x", a_if.ball_x, 618);
    chk("r2_left_y", a_if.ball_y, 72);
    run_ticks(304);
    chk("r2_x_m305", a_if.ball_x, 10);
    chk("r2_y_m305", a_if.ball_y, 262);
    next_tick();
    chk("r2_miss_x", a_if.ball_x, 10);
    chk("r2_miss_y", a_if.ball_y, 260);
    chk("r2_score2", a_if.score2, 1);
    chk("r2_pulse", {a_if.point_p1, a_if.point_p2}, 2'b01);
    chk("r2_p1_pulses", p1_pulses, 1);
    run_ticks(60);
    chk("r2_idle", a_if.game_state, 0);
    run_ticks(3);
    chk("r2_serve_ignored", a_if.game_state, 0);
    chk("r2_p2_pulses", p2_pulses, 1);

    // Round 3: served left, second miss for player 1 ends the game
    serve_a();
    next_tick();
    next_tick();
    chk("r3_x_n1", a_if.ball_x, 313);
    chk("r3_y_n1", a_if.ball_y, 237);
    run_ticks(151);
    chk("r3_x_n152", a_if.ball_x, 11);
    chk("r3_y_n152", a_if.ball_y, 402);
    next_tick();
    chk("r3_miss_y", a_if.ball_y, 400);
    chk("r3_score2", a_if.score2, 2);
    chk("r3_point", a_if.game_state, 2);
    run_ticks(60);
    chk("r3_over", a_if.game_state, 3);
    chk("r3_s1", a_if.score1, 1);
    chk("r3_s2", a_if.score2, 2);

    a_if.p1_up = 1'b1;
    a_if.p2_up = 1'b1;
    run_ticks(5);
    a_if.p1_up = 1'b0;
    a_if.p2_up = 1'b0;
    chk("over_pad1", a_if.paddle1_y, 420);
    chk("over_pad2", a_if.paddle2_y, 40);
    serve_a();
    next_tick();
    chk("over_idle", a_if.game_state, 0);
    chk("over_s1", a_if.score1, 0);
    chk("over_s2", a_if.score2, 0);
    chk("over_ctr_x", a_if.ball_x, 315);
    chk("over_ctr_y", a_if.ball_y, 235);
    serve_a();
    next_tick();
    next_tick();
    chk("r4_x_n1", a_if.ball_x, 317);
    chk("r4_y_n1", a_if.ball_y, 237);

    // Asynchronous reset between clock edges
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ball_x", a_if.ball_x, 315);
    chk("arst_ball_y", a_if.ball_y, 235);
    chk("arst_pad1", a_if.paddle1_y, 210);
    chk("arst_pad2", a_if.paddle2_y, 210);
    chk("arst_state", a_if.game_state, 0);
    chk("arst_tick", a_if.tick, 0);
    chk("arst_b_ball_y", b_if.ball_y, 15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
